// File: rtl/io_cond_pkg.sv
// io_cond_pkg: shared defaults and helpers for the input-conditioning blocks
package io_cond_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int STABLE_CYCLES_DEF = 16;
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel of synchronizer, mismatch counter, clean level and edge pulses
module debounce_ch
    import io_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic en,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic s;
    assign s = sync[SYNC_STAGES-1];
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 1");
    end
    // A match with the clean level always restarts the count, even without en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt   <= '0;
            level <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == level) cnt <= '0;
            else if (en && cnt == LAST) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= !s;
            end else if (en) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dual_input_debounce.sv
// dual_input_debounce: two independent synchronize-and-debounce channels feeding the AND stage
module dual_input_debounce
    import io_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic en,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);
    debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES), .RESET_LEVEL(RESET_LEVEL)) u_a (
        .clk(clk), .reset(reset), .raw(a_raw), .en(en), .level(a), .rise(a_rise), .fall(a_fall)
    );
    debounce_ch #(.SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES), .RESET_LEVEL(RESET_LEVEL)) u_b (
        .clk(clk), .reset(reset), .raw(b_raw), .en(en), .level(b), .rise(b_rise), .fall(b_fall)
    );
endmodule
